// File: rtl/branch_resolve_unit.sv
// In-order queue of fetched branch predictions, resolved oldest-first in EX.
// Produces the registered BHT update and the mispredict redirect/flush.
module branch_resolve_unit #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_push,
    input  logic [9:0]       if_pc,
    input  logic             if_pred,
    input  logic             ex_valid,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    input  logic [31:0]      ex_pc_plus4,
    output logic             upd_valid,
    output logic [9:0]       upd_addr,
    output logic             upd_res,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             q_full,
    output logic             q_empty,
    output logic             overflow,
    output logic             underflow,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

    logic [9:0]       r_pc_q   [DEPTH];
    logic             r_pred_q [DEPTH];

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_count;

    logic             r_upd_valid;
    logic [9:0]       r_upd_addr;
    logic             r_upd_res;
    logic             r_redirect;
    logic [31:0]      r_redirect_pc;
    logic             r_overflow;
    logic             r_underflow;
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_miss_cnt;

    logic             w_empty;
    logic             w_full;
    logic [AW-1:0]    w_rd_idx;
    logic [AW-1:0]    w_wr_idx;
    logic             w_pop;
    logic             w_miss;
    logic             w_cpop;
    logic             w_push_ok;
    logic             w_push_ovf;

    always_comb begin
        w_empty    = (r_count == '0);
        w_full     = (r_count == FULL_CNT);
        w_rd_idx   = r_rd_ptr[AW-1:0];
        w_wr_idx   = r_wr_ptr[AW-1:0];
        w_pop      = ex_valid & ~w_empty;
        w_miss     = w_pop & (r_pred_q[w_rd_idx] ^ ex_taken);
        w_cpop     = w_pop & ~w_miss;
        // A push alongside a mispredict is wrong-path: neither accepted nor an overflow.
        w_push_ok  = if_push & ~w_miss & (~w_full | w_cpop);
        w_push_ovf = if_push & ~w_miss & w_full & ~w_cpop;
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_pc_q[w_wr_idx]   <= if_pc;
            r_pred_q[w_wr_idx] <= if_pred;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_miss) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_cpop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push_ok && !w_cpop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push_ok && w_cpop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_upd_valid   <= 1'b0;
            r_upd_addr    <= '0;
            r_upd_res     <= 1'b0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
            r_br_cnt      <= '0;
            r_miss_cnt    <= '0;
        end else begin
            r_upd_valid <= w_pop;
            r_redirect  <= w_miss;
            if (w_pop) begin
                r_upd_addr <= r_pc_q[w_rd_idx];
                r_upd_res  <= ~w_miss;
                if (r_br_cnt != '1) begin
                    r_br_cnt <= r_br_cnt + 1'b1;
                end
            end
            if (w_miss) begin
                r_redirect_pc <= ex_taken ? ex_target : ex_pc_plus4;
                if (r_miss_cnt != '1) begin
                    r_miss_cnt <= r_miss_cnt + 1'b1;
                end
            end
            if (w_push_ovf) begin
                r_overflow <= 1'b1;
            end
            if (ex_valid && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign upd_valid   = r_upd_valid;
    assign upd_addr    = r_upd_addr;
    assign upd_res     = r_upd_res;
    assign redirect    = r_redirect;
    assign redirect_pc = r_redirect_pc;
    assign q_full      = w_full;
    assign q_empty     = w_empty;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;
    assign br_cnt      = r_br_cnt;
    assign miss_cnt    = r_miss_cnt;

endmodule
